// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter: response owner,
// fault codes and the response pipeline register layout.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;

    localparam logic [3:0] EXC_IMISALIGN = 4'd0;
    localparam logic [3:0] EXC_IACCESS   = 4'd1;
    localparam logic [3:0] EXC_LMISALIGN = 4'd4;
    localparam logic [3:0] EXC_LACCESS   = 4'd5;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        owner_e      owner;
        logic        fault;
        logic [3:0]  code;
        logic [63:0] addr;
    } rsp_t;

endpackage

// File: rtl/imem_fault_chk.sv
// Combinational address check for one read port: flags misaligned or
// out-of-range byte addresses and selects the port's exception code.
module imem_fault_chk
    import imem_arb_pkg::*;
#(
    parameter int         MEM_WORDS     = 2048,
    parameter int         IDX_W         = $clog2(MEM_WORDS),
    parameter logic [3:0] MISALIGN_CODE = EXC_IMISALIGN,
    parameter logic [3:0] ACCESS_CODE   = EXC_IACCESS
) (
    input  logic [63:0] addr,
    output logic        fault,
    output logic [3:0]  code
);

    logic misaligned;
    logic out_of_range;

    // MEM_WORDS is a power of two, so any set bit above the index field is out of range.
    assign misaligned   = (addr[1:0] != 2'b00);
    assign out_of_range = (addr[63:IDX_W+2] != '0);

    always_comb begin
        fault = misaligned | out_of_range;
        code  = 4'd0;
        if (misaligned) begin
            code = MISALIGN_CODE;
        end else if (out_of_range) begin
            code = ACCESS_CODE;
        end
    end

endmodule

// File: rtl/imem_arb.sv
// Single-port instruction memory arbiter: write > load > fetch, with fetch
// promoted above loads after STARVE_MAX consecutive denials; one-cycle read responses.
module imem_arb
    import imem_arb_pkg::*;
#(
    parameter int MEM_WORDS  = 2048,
    parameter int IDX_W      = $clog2(MEM_WORDS),
    parameter int STARVE_MAX = 2
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             f_req,
    input  logic [63:0]      f_addr,
    output logic             f_gnt,
    output logic             f_rvalid,
    output logic [31:0]      f_rdata,
    output logic             f_exc_en,
    output logic [3:0]       f_exc_code,
    output logic [63:0]      f_exc_val,

    input  logic             l_req,
    input  logic [63:0]      l_addr,
    output logic             l_gnt,
    output logic             l_rvalid,
    output logic [31:0]      l_rdata,
    output logic             l_exc_en,
    output logic [3:0]       l_exc_code,
    output logic [63:0]      l_exc_val,

    input  logic             w_req,
    input  logic [IDX_W-1:0] w_idx,
    input  logic [31:0]      w_data,
    output logic             w_gnt,

    output logic             m_en,
    output logic             m_we,
    output logic [IDX_W-1:0] m_idx,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q, starve_d;
    rsp_t             rsp_q, rsp_d;

    logic             promote;
    logic             f_fault, l_fault;
    logic [3:0]       f_code, l_code;
    logic             f_valid, l_valid;

    imem_fault_chk #(
        .MEM_WORDS     (MEM_WORDS),
        .IDX_W         (IDX_W),
        .MISALIGN_CODE (EXC_IMISALIGN),
        .ACCESS_CODE   (EXC_IACCESS)
    ) u_fetch_chk (
        .addr  (f_addr),
        .fault (f_fault),
        .code  (f_code)
    );

    imem_fault_chk #(
        .MEM_WORDS     (MEM_WORDS),
        .IDX_W         (IDX_W),
        .MISALIGN_CODE (EXC_LMISALIGN),
        .ACCESS_CODE   (EXC_LACCESS)
    ) u_load_chk (
        .addr  (l_addr),
        .fault (l_fault),
        .code  (l_code)
    );

    assign promote = (starve_q == STARVE_LIM);

    // Grants are gated by rst so nothing is accepted during the reset cycle.
    always_comb begin
        w_gnt = 1'b0;
        l_gnt = 1'b0;
        f_gnt = 1'b0;
        if (!rst) begin
            if (w_req) begin
                w_gnt = 1'b1;
            end else if (f_req && (promote || !l_req)) begin
                f_gnt = 1'b1;
            end else if (l_req) begin
                l_gnt = 1'b1;
            end
        end
    end

    // Counter saturates so a write blocking a promoted fetch cannot wrap it back to zero.
    always_comb begin
        starve_d = starve_q;
        if (f_gnt) begin
            starve_d = '0;
        end else if (f_req && !promote) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        rsp_d = '{owner: OWN_NONE, fault: 1'b0, code: 4'd0, addr: 64'd0};
        if (f_gnt) begin
            rsp_d = '{owner: OWN_FETCH, fault: f_fault, code: f_code, addr: f_addr};
        end else if (l_gnt) begin
            rsp_d = '{owner: OWN_LOAD, fault: l_fault, code: l_code, addr: l_addr};
        end
    end

    always_comb begin
        m_en    = w_gnt | (l_gnt & ~l_fault) | (f_gnt & ~f_fault);
        m_we    = w_gnt;
        m_wdata = w_data;
        m_idx   = f_addr[IDX_W+1:2];
        if (w_gnt) begin
            m_idx = w_idx;
        end else if (l_gnt) begin
            m_idx = l_addr[IDX_W+1:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            rsp_q    <= '{owner: OWN_NONE, fault: 1'b0, code: 4'd0, addr: 64'd0};
        end else begin
            starve_q <= starve_d;
            rsp_q    <= rsp_d;
        end
    end

    // Responses are masked during rst so a read in flight at reset never surfaces.
    always_comb begin
        f_valid    = !rst && (rsp_q.owner == OWN_FETCH);
        l_valid    = !rst && (rsp_q.owner == OWN_LOAD);

        f_rvalid   = f_valid;
        f_rdata    = (f_valid && !rsp_q.fault) ? m_rdata : NOP_INSN;
        f_exc_en   = f_valid && rsp_q.fault;
        f_exc_code = f_exc_en ? rsp_q.code : 4'd0;
        f_exc_val  = f_exc_en ? rsp_q.addr : 64'd0;

        l_rvalid   = l_valid;
        l_rdata    = (l_valid && !rsp_q.fault) ? m_rdata : 32'd0;
        l_exc_en   = l_valid && rsp_q.fault;
        l_exc_code = l_exc_en ? rsp_q.code : 4'd0;
        l_exc_val  = l_exc_en ? rsp_q.addr : 64'd0;
    end

endmodule

// File: tb/tb_imem_arb.sv
// Scoreboard bench for imem_arb: directed scenarios followed by random traffic,
// checked against a priority/fault reference model and a shadow memory image.
module tb_imem_arb;
    import imem_arb_pkg::*;

    localparam int MEM_WORDS = 2048;
    localparam int IDX_W     = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             f_req, l_req, w_req;
    logic [63:0]      f_addr, l_addr;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_data;
    logic             f_gnt, l_gnt, w_gnt;
    logic             f_rvalid, l_rvalid, f_exc_en, l_exc_en;
    logic [31:0]      f_rdata, l_rdata;
    logic [3:0]       f_exc_code, l_exc_code;
    logic [63:0]      f_exc_val, l_exc_val;
    logic             m_en, m_we;
    logic [IDX_W-1:0] m_idx;
    logic [31:0]      m_wdata, m_rdata;

    typedef struct {
        bit          is_fetch;
        bit          exc;
        logic [3:0]  code;
        logic [63:0] val;
        logic [31:0] data;
        int          cycle;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          starve = 0;
    bit          eg_f, eg_l, eg_w;
    logic [31:0] mem[MEM_WORDS];
    logic [31:0] ref_mem[MEM_WORDS];

    imem_arb #(.MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W), .STARVE_MAX(2)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .f_exc_en(f_exc_en), .f_exc_code(f_exc_code), .f_exc_val(f_exc_val),
        .l_req(l_req), .l_addr(l_addr), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .l_exc_en(l_exc_en), .l_exc_code(l_exc_code), .l_exc_val(l_exc_val),
        .w_req(w_req), .w_idx(w_idx), .w_data(w_data), .w_gnt(w_gnt),
        .m_en(m_en), .m_we(m_we), .m_idx(m_idx), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // External single-port array with one-cycle synchronous read.
    initial begin
        m_rdata = 32'd0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (m_en) begin
                if (m_we) mem[m_idx] = m_wdata;
                else      m_rdata <= mem[m_idx];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t make_exp(input bit is_fetch, input logic [63:0] addr);
        exp_t e;
        e.is_fetch = is_fetch;
        e.val      = addr;
        e.exc      = 1'b1;
        if (addr % 4 != 0) begin
            e.code = is_fetch ? 4'd0 : 4'd4;
        end else if ((addr / 4) >= MEM_WORDS) begin
            e.code = is_fetch ? 4'd1 : 4'd5;
        end else begin
            e.exc  = 1'b0;
            e.code = 4'd0;
        end
        if (e.exc)         e.data = is_fetch ? 32'h0000_0013 : 32'd0;
        else               e.data = ref_mem[int'(addr / 4)];
        e.cycle = cyc;
        return e;
    endfunction

    task automatic checkOutput();
        exp_t e;
        bit   rd;
        if (rst) begin
            eg_f = 0; eg_l = 0; eg_w = 0; starve = 0;
            check("rst_f_gnt", f_gnt, 0);
            check("rst_l_gnt", l_gnt, 0);
            check("rst_w_gnt", w_gnt, 0);
            check("rst_f_rvalid", f_rvalid, 0);
            check("rst_l_rvalid", l_rvalid, 0);
            check("rst_f_exc_en", f_exc_en, 0);
            check("rst_l_exc_en", l_exc_en, 0);
            check("rst_f_exc_code", f_exc_code, 0);
            check("rst_l_exc_code", l_exc_code, 0);
            check("rst_f_exc_val", f_exc_val, 0);
            check("rst_l_exc_val", l_exc_val, 0);
            check("rst_f_rdata", f_rdata, 64'h13);
            check("rst_l_rdata", l_rdata, 0);
            check("rst_m_en", m_en, 0);
            check("rst_m_we", m_we, 0);
            return;
        end
        eg_w = w_req;
        eg_f = !w_req && f_req && (starve >= 2 || !l_req);
        eg_l = !w_req && l_req && !eg_f;
        check("w_gnt", w_gnt, eg_w);
        check("f_gnt", f_gnt, eg_f);
        check("l_gnt", l_gnt, eg_l);
        rd = 0;
        if (eg_f) begin e = make_exp(1, f_addr); rd = 1; end
        else if (eg_l) begin e = make_exp(0, l_addr); rd = 1; end
        check("m_en", m_en, eg_w || (rd && !e.exc));
        check("m_we", m_we, eg_w);
        if (eg_w) begin
            check("m_idx_wr", m_idx, w_idx);
            check("m_wdata", m_wdata, w_data);
            ref_mem[w_idx] = w_data;
        end
        if (rd) begin
            if (!e.exc) check("m_idx_rd", m_idx, e.val / 4);
            sb.push_back(e);
        end
        if (eg_f)        starve = 0;
        else if (f_req)  starve = (starve < 2) ? starve + 1 : 2;
    endtask

    task automatic applyStimulus(input bit r, input bit fr, input logic [63:0] fa,
                                 input bit lr, input logic [63:0] la,
                                 input bit wr, input logic [IDX_W-1:0] wi, input logic [31:0] wd);
        @(posedge clk);
        #1;
        if (r) sb.delete();
        rst = r; f_req = fr; f_addr = fa; l_req = lr; l_addr = la;
        w_req = wr; w_idx = wi; w_data = wd;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pairs every response with the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cycle + 1 < cyc) begin
            n_cmp++; n_fail++;
            $display("[TB] FAIL missing_rvalid: grant at cycle %0d got no response, expected one at cycle %0d",
                     sb[0].cycle, sb[0].cycle + 1);
            void'(sb.pop_front());
        end
        check("rvalid_onehot", f_rvalid & l_rvalid, 0);
        if (f_rvalid || l_rvalid) begin
            if (sb.size() == 0 || sb[0].cycle + 1 != cyc) begin
                n_cmp++; n_fail++;
                $display("[TB] FAIL unexpected_rvalid @cycle %0d: got f=%0b l=%0b expected none",
                         cyc, f_rvalid, l_rvalid);
            end else begin
                e = sb.pop_front();
                check("rsp_owner_fetch", f_rvalid, e.is_fetch);
                if (e.is_fetch) begin
                    check("f_rdata", f_rdata, e.data);
                    check("f_exc_en", f_exc_en, e.exc);
                    check("f_exc_code", f_exc_code, e.exc ? e.code : 4'd0);
                    check("f_exc_val", f_exc_val, e.exc ? e.val : 64'd0);
                end else begin
                    check("l_rdata", l_rdata, e.data);
                    check("l_exc_en", l_exc_en, e.exc);
                    check("l_exc_code", l_exc_code, e.exc ? e.code : 4'd0);
                    check("l_exc_val", l_exc_val, e.exc ? e.val : 64'd0);
                end
            end
        end
    end

    function automatic logic [63:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 64'($urandom_range(0, MEM_WORDS - 1)) * 4 + 64'($urandom_range(1, 3));
        if (sel == 1) return 64'h2000 + 64'($urandom_range(0, 4095)) * 4;
        if (sel == 2) return {32'($urandom) | 32'h1, 32'h0};
        return 64'($urandom_range(0, MEM_WORDS - 1)) * 4;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit              fr, lr, wr, r;
        logic [63:0]     fa, la;
        logic [IDX_W-1:0] wi;
        logic [31:0]     wd;
        bit [5:0]        fpat;

        rst = 1; f_req = 0; l_req = 0; w_req = 0;
        f_addr = 0; l_addr = 0; w_idx = 0; w_data = 0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] fetch hit and faults");
        applyStimulus(0, 1, 64'h10, 0, 0, 0, 0, 0);
        idle();
        applyStimulus(0, 1, 64'h2000, 0, 0, 0, 0, 0);
        idle();
        applyStimulus(0, 0, 0, 1, 64'h6, 0, 0, 0);
        idle();

        $display("[TB] held fetch and load, starvation promotion");
        fpat = 6'b100100;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 64'h20, 1, 64'h24, 0, 0, 0);
            check("promo_seq_f_gnt", f_gnt, fpat[i]);
        end
        idle();

        $display("[TB] write then read-after-write");
        applyStimulus(0, 0, 0, 0, 0, 1, 11'd7, 32'h1234_5678);
        applyStimulus(0, 1, 64'h1C, 0, 0, 0, 0, 0);
        idle();

        $display("[TB] all three requesting");
        applyStimulus(0, 1, 64'h30, 1, 64'h34, 1, 11'd9, 32'hCAFE_F00D);
        idle();
        idle();

        $display("[TB] reset after load grant");
        applyStimulus(0, 0, 0, 1, 64'h40, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();

        $display("[TB] random traffic");
        fr = 0; lr = 0; fa = 0; la = 0;
        for (int n = 0; n < 800; n++) begin
            r = ($urandom_range(0, 63) == 0);
            if (!fr || eg_f) begin fr = ($urandom_range(0, 3) != 0); fa = rand_addr(); end
            if (!lr || eg_l) begin lr = ($urandom_range(0, 2) == 0); la = rand_addr(); end
            wr = ($urandom_range(0, 5) == 0);
            wi = IDX_W'($urandom_range(0, 63));
            wd = $urandom;
            if (!fr && $urandom_range(0, 1) == 0) fa = 64'(wi) * 4;
            applyStimulus(r, fr, fa, lr, la, wr, wi, wd);
        end

        idle();
        idle();
        idle();
        check("scoreboard_drained", 64'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_arb.md
# imem_arb

Arbiter and sequencer for the single-port instruction memory. Shares one synchronous-read word array between three requesters: core instruction fetch, core data loads that target instruction space, and the boot/test loader's write port. Generates instruction- and load-access faults for out-of-range or misaligned requests. Sits between the fetch stage / LSU and the memory array macro.

## Interface
- MEM_WORDS, 2048, number of 32-bit words in the array (power of two)
- IDX_W, $clog2(MEM_WORDS), word-index width
- STARVE_MAX, 2, consecutive fetch denials before fetch is promoted to top priority
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- f_req / f_addr  in  1 / 64  fetch request and byte address; held until f_gnt
- f_gnt  out  1  fetch accepted this cycle (combinational)
- f_rvalid / f_rdata  out  1 / 32  fetch response; rdata = 0x00000013 on fault
- f_exc_en / f_exc_code / f_exc_val  out  1 / 4 / 64  fetch fault: code 1 (access) or 0 (misaligned), val = f_addr
- l_req / l_addr  in  1 / 64  load request (word); held until l_gnt
- l_gnt  out  1  load accepted
- l_rvalid / l_rdata  out  1 / 32  load response; rdata = 0 on fault
- l_exc_en / l_exc_code / l_exc_val  out  1 / 4 / 64  load fault: code 5 (access) or 4 (misaligned), val = l_addr
- w_req / w_idx / w_data  in  1 / IDX_W / 32  loader write
- w_gnt  out  1  write accepted
- m_en / m_we / m_idx / m_wdata  out  1 / 1 / IDX_W / 32  memory port
- m_rdata  in  32  memory read data, valid one cycle after m_en & !m_we

## Operation
- At most one grant per cycle. Default priority: write > load > fetch.
- Starvation counter: increments when f_req high and f_gnt low; clears on f_gnt or rst. When counter == STARVE_MAX, fetch outranks load (not write).
- Fault check on granted read: misaligned if addr[1:0] != 0; access fault if addr[63:2] >= MEM_WORDS. Misaligned takes precedence. Faulted request is granted but drives m_en = 0.
- Writes never fault (index already IDX_W wide).
- Response pipeline register holds {owner, fault, code, addr}; owner FETCH/LOAD/NONE. Cycle after grant, owner's rvalid pulses one cycle; rdata from m_rdata, or fault constant.
- exc_en is a one-cycle pulse aligned with rvalid; a held faulting request produces exactly one fault per grant.
- Back-to-back grants permitted every cycle; no stall on response side (requesters must sink responses).

## Timing
- Grant: same cycle as request (combinational from req, counter, priority).
- Read latency: rvalid exactly 1 cycle after gnt, both for memory hits and faults.
- Write: takes effect at clock edge of grant; a read of same index granted next cycle returns new data.
- Reset: all gnt, rvalid, exc_en, m_en, m_we = 0; exc_code = 0; exc_val = 0; l_rdata = 0; f_rdata = 0x00000013; owner = NONE; counter = 0. Response in flight at rst is discarded (no rvalid after reset).
- Simultaneous f_req, l_req, w_req: w granted; counter increments; l then f on subsequent cycles unless promotion.

## Structure
- Shared package: owner enum (NONE, FETCH, LOAD), exception codes (EXC_IMISALIGN=0, EXC_IACCESS=1, EXC_LMISALIGN=4, EXC_LACCESS=5), NOP constant 0x00000013.
- One sub-module natural: imem_fault_chk (combinational addr -> {fault, code}), instantiated once per read port.
- Array itself is external; imem_arb contains no storage beyond response register and counter.

## Test plan
- Fetch only, f_addr = 0x10 with word[4]=0xDEADBEEF -> f_gnt same cycle, f_rvalid next cycle, f_rdata 0xDEADBEEF, f_exc_en 0.
- Fetch f_addr = 0x2000 (index 2048) -> f_rvalid + f_exc_en one cycle, code 1, val 0x2000, rdata 0x13, m_en 0; l_addr = 0x6 -> code 4.
- f_req and l_req held continuously -> grants L, L, F, L, L, F (promotion at STARVE_MAX=2).
- w_req idx 7 data 0x12345678, then fetch 0x1C next cycle -> f_rdata 0x12345678.
- All three requesting -> w_gnt only; no rvalid next cycle.
- rst asserted the cycle after a load grant -> no l_rvalid; all outputs at reset values.
